calc_sequencer: RTL and testbench

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_sequencer.sv | 137 +++++++++++++
 tb/tb_calc_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// Operand-entry sequencer for a keypad calculator: it latches N_OPS operands on
// button presses, then alternates between showing a result and chaining it forward.
module calc_sequencer #(
    parameter int DATA_W = 40,
    parameter int N_OPS  = 2,
    parameter int LED_W  = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      btn_clear,
    input  logic                      btn_next,
    input  logic                      enable_switch,
    input  logic [DATA_W-1:0]         in_val,
    input  logic [DATA_W-1:0]         in_prev_res,
    output logic [N_OPS*DATA_W-1:0]   ops,
    output logic [1:0]                op_idx,
    output logic [1:0]                display_sel,
    output logic [LED_W-1:0]          led,
    output logic                      calc_start
);

    typedef enum logic [1:0] {
        ST_ENTRY  = 2'd0,
        ST_RESULT = 2'd1,
        ST_CONT   = 2'd2
    } state_t;

    localparam logic [1:0] LAST_IDX = 2'(N_OPS - 1);

    state_t                         state_q, state_d;
    logic [N_OPS-1:0][DATA_W-1:0]   ops_q, ops_d;
    logic [1:0]                     op_idx_q, op_idx_d;
    logic [1:0]                     disp_q, disp_d;
    logic [LED_W-1:0]               led_q, led_d;
    logic                           start_q, start_d;
    logic                           next_hist_q, next_hist_d;
    logic                           clear_hist_q, clear_hist_d;
    logic                           next_evt;
    logic                           clear_evt;

    // History flops reset to 1 so a button held through reset release is ignored.
    assign next_hist_d  = btn_next;
    assign clear_hist_d = btn_clear;
    assign next_evt     = btn_next & ~next_hist_q & enable_switch;
    assign clear_evt    = btn_clear & ~clear_hist_q;

    always_comb begin
        state_d  = state_q;
        ops_d    = ops_q;
        op_idx_d = op_idx_q;
        disp_d   = disp_q;
        led_d    = led_q;
        start_d  = 1'b0;

        if (clear_evt) begin
            state_d  = ST_ENTRY;
            ops_d    = '0;
            op_idx_d = 2'd0;
            disp_d   = 2'b00;
            led_d    = '0;
        end else if (next_evt) begin
            case (state_q)
                ST_ENTRY: begin
                    for (int k = 0; k < N_OPS; k++) begin
                        if (op_idx_q == 2'(k)) begin
                            ops_d[k] = in_val;
                        end
                    end
                    led_d = LED_W'(1) << op_idx_q;
                    if (op_idx_q == LAST_IDX) begin
                        state_d = ST_RESULT;
                        disp_d  = 2'b11;
                        start_d = 1'b1;
                    end else begin
                        op_idx_d = op_idx_q + 2'd1;
                        disp_d   = 2'b01;
                    end
                end
                ST_RESULT: begin
                    state_d  = ST_CONT;
                    op_idx_d = 2'd1;
                    disp_d   = 2'b01;
                    led_d    = LED_W'(1) << N_OPS;
                end
                ST_CONT: begin
                    // The previous result becomes operand 0 so computations can chain.
                    ops_d[0] = in_prev_res;
                    ops_d[1] = in_val;
                    led_d    = LED_W'(1) << (N_OPS + 1);
                    if (N_OPS == 2) begin
                        state_d  = ST_RESULT;
                        op_idx_d = LAST_IDX;
                        disp_d   = 2'b11;
                        start_d  = 1'b1;
                    end else begin
                        state_d  = ST_ENTRY;
                        op_idx_d = 2'd2;
                        disp_d   = 2'b01;
                    end
                end
                default: begin
                    state_d  = ST_ENTRY;
                    op_idx_d = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_ENTRY;
            ops_q        <= '0;
            op_idx_q     <= 2'd0;
            disp_q       <= 2'b00;
            led_q        <= '1;
            start_q      <= 1'b0;
            next_hist_q  <= 1'b1;
            clear_hist_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            ops_q        <= ops_d;
            op_idx_q     <= op_idx_d;
            disp_q       <= disp_d;
            led_q        <= led_d;
            start_q      <= start_d;
            next_hist_q  <= next_hist_d;
            clear_hist_q <= clear_hist_d;
        end
    end

    assign ops         = ops_q;
    assign op_idx      = op_idx_q;
    assign display_sel = disp_q;
    assign led         = led_q;
    assign calc_start  = start_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: one N_OPS=2 and one N_OPS=3 instance,
// stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_calc_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic         a_clr = 0, a_next = 0, a_en = 1;
    logic [39:0]  a_val = '0, a_prev = '0;
    logic [79:0]  a_ops;
    logic [1:0]   a_idx, a_disp;
    logic [9:0]   a_led;
    logic         a_start;

    logic         b_clr = 0, b_next = 0, b_en = 1;
    logic [39:0]  b_val = '0, b_prev = '0;
    logic [119:0] b_ops;
    logic [1:0]   b_idx, b_disp;
    logic [9:0]   b_led;
    logic         b_start;

    typedef struct {
        int           stamp;
        bit           dut;
        string        name;
        logic [119:0] ops;
        logic [1:0]   idx;
        logic [1:0]   disp;
        logic [9:0]   led;
        logic         start;
    } exp_t;

    exp_t sb[$];
    exp_t mon_item;

    calc_sequencer #(.DATA_W(40), .N_OPS(2), .LED_W(10)) dut_a (
        .clk(clk), .reset(reset), .btn_clear(a_clr), .btn_next(a_next),
        .enable_switch(a_en), .in_val(a_val), .in_prev_res(a_prev),
        .ops(a_ops), .op_idx(a_idx), .display_sel(a_disp), .led(a_led),
        .calc_start(a_start)
    );

    calc_sequencer #(.DATA_W(40), .N_OPS(3), .LED_W(10)) dut_b (
        .clk(clk), .reset(reset), .btn_clear(b_clr), .btn_next(b_next),
        .enable_switch(b_en), .in_val(b_val), .in_prev_res(b_prev),
        .ops(b_ops), .op_idx(b_idx), .display_sel(b_disp), .led(b_led),
        .calc_start(b_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [119:0] ops2(input logic [39:0] o0, input logic [39:0] o1);
        return {40'd0, o1, o0};
    endfunction

    function automatic logic [119:0] ops3(input logic [39:0] o0, input logic [39:0] o1,
                                          input logic [39:0] o2);
        return {o2, o1, o0};
    endfunction

    task automatic check_output(input int stamp, input bit d, input string name,
                                input logic [119:0] eops, input logic [1:0] eidx,
                                input logic [1:0] edisp, input logic [9:0] eled,
                                input logic estart);
        exp_t e;
        e.stamp = stamp; e.dut = d; e.name = name; e.ops = eops;
        e.idx = eidx; e.disp = edisp; e.led = eled; e.start = estart;
        sb.push_back(e);
    endtask

    task automatic apply_stimulus(input bit d, input logic nxt, input logic clr,
                                  input logic [39:0] val, input logic [39:0] prev);
        @(posedge clk);
        #1;
        if (d == 1'b0) begin
            a_next = nxt; a_clr = clr; a_val = val; a_prev = prev;
        end else begin
            b_next = nxt; b_clr = clr; b_val = val; b_prev = prev;
        end
    endtask

    task automatic step(input bit d, input logic nxt, input logic clr,
                        input logic [39:0] val, input logic [39:0] prev,
                        input string name, input logic [119:0] eops,
                        input logic [1:0] eidx, input logic [1:0] edisp,
                        input logic [9:0] eled, input logic estart);
        apply_stimulus(d, nxt, clr, val, prev);
        check_output(cyc + 1, d, name, eops, eidx, edisp, eled, estart);
    endtask

    task automatic cmp(input string name, input string field,
                       input logic [119:0] act, input logic [119:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s.%s at cycle %0d: got %h expected %h",
                     name, field, cyc, act, exp_v);
        end
    endtask

    // Monitor: compares every expectation due in the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].stamp <= cyc) begin
            mon_item = sb.pop_front();
            if (mon_item.stamp < cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s stale: got cycle %0d expected cycle %0d",
                         mon_item.name, cyc, mon_item.stamp);
            end else if (mon_item.dut == 1'b0) begin
                cmp(mon_item.name, "ops",   {40'd0, a_ops}, mon_item.ops);
                cmp(mon_item.name, "idx",   120'(a_idx),    120'(mon_item.idx));
                cmp(mon_item.name, "disp",  120'(a_disp),   120'(mon_item.disp));
                cmp(mon_item.name, "led",   120'(a_led),    120'(mon_item.led));
                cmp(mon_item.name, "start", 120'(a_start),  120'(mon_item.start));
            end else begin
                cmp(mon_item.name, "ops",   b_ops,          mon_item.ops);
                cmp(mon_item.name, "idx",   120'(b_idx),    120'(mon_item.idx));
                cmp(mon_item.name, "disp",  120'(b_disp),   120'(mon_item.disp));
                cmp(mon_item.name, "led",   120'(b_led),    120'(mon_item.led));
                cmp(mon_item.name, "start", 120'(b_start),  120'(mon_item.start));
            end
        end
    end

    initial begin
        $display("[TB] calc_sequencer bench start");
        @(posedge clk);
        #1;
        check_output(cyc, 0, "a_reset", '0, 2'd0, 2'b00, 10'h3FF, 1'b0);
        check_output(cyc, 1, "b_reset", '0, 2'd0, 2'b00, 10'h3FF, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Two operands then result: 5 and 7.
        step(0, 0, 0, 40'd0, 40'd0, "a_idle",   ops2(0, 0),  2'd0, 2'b00, 10'h3FF, 0);
        step(0, 1, 0, 40'd5, 40'd0, "a_op0",    ops2(5, 0),  2'd1, 2'b01, 10'h001, 0);
        step(0, 0, 0, 40'd5, 40'd0, "a_op0h",   ops2(5, 0),  2'd1, 2'b01, 10'h001, 0);
        step(0, 1, 0, 40'd7, 40'd0, "a_op1",    ops2(5, 7),  2'd1, 2'b11, 10'h002, 1);
        step(0, 0, 0, 40'd7, 40'd0, "a_res",    ops2(5, 7),  2'd1, 2'b11, 10'h002, 0);
        step(0, 1, 0, 40'd9, 40'd0, "a_cont",   ops2(5, 7),  2'd1, 2'b01, 10'h004, 0);
        step(0, 0, 0, 40'd9, 40'd0, "a_conth",  ops2(5, 7),  2'd1, 2'b01, 10'h004, 0);
        step(0, 1, 0, 40'd3, 40'd12, "a_chain", ops2(12, 3), 2'd1, 2'b11, 10'h008, 1);
        step(0, 0, 0, 40'd3, 40'd12, "a_chainh", ops2(12, 3), 2'd1, 2'b11, 10'h008, 0);

        // Held button: one transition only.
        step(0, 1, 0, 40'd1, 40'd2, "a_held0", ops2(12, 3), 2'd1, 2'b01, 10'h004, 0);
        for (int i = 0; i < 9; i++) begin
            step(0, 1, 0, 40'd1, 40'd2, "a_held", ops2(12, 3), 2'd1, 2'b01, 10'h004, 0);
        end
        step(0, 0, 0, 40'd1, 40'd2, "a_rel", ops2(12, 3), 2'd1, 2'b01, 10'h004, 0);

        // Disabled advance is discarded.
        a_en = 1'b0;
        step(0, 1, 0, 40'd1, 40'd2, "a_dis1", ops2(12, 3), 2'd1, 2'b01, 10'h004, 0);
        step(0, 0, 0, 40'd1, 40'd2, "a_dis0", ops2(12, 3), 2'd1, 2'b01, 10'h004, 0);
        a_en = 1'b1;
        step(0, 0, 0, 40'd1, 40'd2, "a_en",   ops2(12, 3), 2'd1, 2'b01, 10'h004, 0);

        // Clear, enter one operand, then clear and next together.
        step(0, 0, 1, 40'd0, 40'd0, "a_clr",   ops2(0, 0), 2'd0, 2'b00, 10'h000, 0);
        step(0, 0, 0, 40'd0, 40'd0, "a_clrh",  ops2(0, 0), 2'd0, 2'b00, 10'h000, 0);
        step(0, 1, 0, 40'd9, 40'd0, "a_e1",    ops2(9, 0), 2'd1, 2'b01, 10'h001, 0);
        step(0, 0, 0, 40'd9, 40'd0, "a_e1h",   ops2(9, 0), 2'd1, 2'b01, 10'h001, 0);
        step(0, 1, 1, 40'd8, 40'd0, "a_both",  ops2(0, 0), 2'd0, 2'b00, 10'h000, 0);
        step(0, 0, 0, 40'd8, 40'd0, "a_bothh", ops2(0, 0), 2'd0, 2'b00, 10'h000, 0);

        // Reach RESULT, then assert reset mid-pulse between clock edges.
        step(0, 1, 0, 40'd4, 40'd0, "a_r0",  ops2(4, 0), 2'd1, 2'b01, 10'h001, 0);
        step(0, 0, 0, 40'd4, 40'd0, "a_r0h", ops2(4, 0), 2'd1, 2'b01, 10'h001, 0);
        apply_stimulus(0, 1, 0, 40'd6, 40'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        check_output(cyc, 0, "a_async", '0, 2'd0, 2'b00, 10'h3FF, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        a_next = 1'b0;
        check_output(cyc + 1, 0, "a_post", '0, 2'd0, 2'b00, 10'h3FF, 0);

        // N_OPS=3 instance.
        step(1, 0, 0, 40'd0, 40'd0, "b_idle", '0, 2'd0, 2'b00, 10'h3FF, 0);
        step(1, 1, 0, 40'd1, 40'd0, "b_op0",  ops3(1, 0, 0), 2'd1, 2'b01, 10'h001, 0);
        step(1, 0, 0, 40'd1, 40'd0, "b_op0h", ops3(1, 0, 0), 2'd1, 2'b01, 10'h001, 0);
        step(1, 1, 0, 40'd2, 40'd0, "b_op1",  ops3(1, 2, 0), 2'd2, 2'b01, 10'h002, 0);
        step(1, 0, 0, 40'd2, 40'd0, "b_op1h", ops3(1, 2, 0), 2'd2, 2'b01, 10'h002, 0);
        step(1, 1, 0, 40'd3, 40'd0, "b_op2",  ops3(1, 2, 3), 2'd2, 2'b11, 10'h004, 1);
        step(1, 0, 0, 40'd3, 40'd0, "b_res",  ops3(1, 2, 3), 2'd2, 2'b11, 10'h004, 0);
        step(1, 1, 0, 40'd3, 40'd0, "b_cont", ops3(1, 2, 3), 2'd1, 2'b01, 10'h008, 0);
        step(1, 0, 0, 40'd3, 40'd0, "b_conth", ops3(1, 2, 3), 2'd1, 2'b01, 10'h008, 0);
        step(1, 1, 0, 40'd8, 40'd20, "b_chain", ops3(20, 8, 3), 2'd2, 2'b01, 10'h010, 0);
        step(1, 0, 0, 40'd8, 40'd20, "b_chainh", ops3(20, 8, 3), 2'd2, 2'b01, 10'h010, 0);
        step(1, 1, 0, 40'd5, 40'd0, "b_op2b", ops3(20, 8, 5), 2'd2, 2'b11, 10'h004, 1);
        step(1, 0, 0, 40'd5, 40'd0, "b_resb", ops3(20, 8, 5), 2'd2, 2'b11, 10'h004, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
